// File: rtl/cdb_issue_scheduler.sv
// cdb_issue_scheduler: books the shared CDB ahead of issue so int/mult/div/ld results never collide.
// Define ISSUE_LRU_EN to alternate int/ld_buf under contention; otherwise int always wins.
module cdb_issue_scheduler #(
   parameter int MULT_LAT = 4,
   parameter int DIV_LAT  = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ready_int,
   input  logic       ready_mult,
   input  logic       ready_div,
   input  logic       ready_ld_buf,
   output logic       issue_int,
   output logic       issue_mult,
   output logic       issue_div,
   output logic       issue_ld_buf,
   output logic       div_busy,
   output logic       cdb_valid,
   output logic [1:0] cdb_sel
);
   logic [DIV_LAT-1:0]      res_q, res_d;
   logic [DIV_LAT-1:0][1:0] own_q, own_d;
   logic [3:0]              div_cnt_q, div_cnt_d;
   logic                    el_int, el_mult, el_div, el_ld, pick_ld;

   assign div_busy  = div_cnt_q != 4'd0;
   assign cdb_valid = res_q[0];
   assign cdb_sel   = own_q[0];

   // a unit of latency L may issue only if slot L is free when its result would land
   assign el_int  = ready_int & ~res_q[1];
   assign el_ld   = ready_ld_buf & ~res_q[1];
   assign el_mult = ready_mult & ~res_q[MULT_LAT];
   assign el_div  = ready_div & ~div_busy;

`ifdef ISSUE_LRU_EN
   logic lru_q;
   assign pick_ld = el_ld & (~el_int | lru_q);
   always_ff @(posedge clk)
      lru_q <= reset ? 1'b0 : issue_int ? 1'b1 : issue_ld_buf ? 1'b0 : lru_q;
`else
   assign pick_ld = el_ld & ~el_int;
`endif

   assign issue_div    = ~reset & el_div;
   assign issue_mult   = ~reset & ~el_div & el_mult;
   assign issue_ld_buf = ~reset & ~el_div & ~el_mult & pick_ld;
   assign issue_int    = ~reset & ~el_div & ~el_mult & el_int & ~pick_ld;

   always_comb begin
      res_d = {1'b0, res_q[DIV_LAT-1:1]};
      own_d = {2'b00, own_q[DIV_LAT-1:1]};
      if (issue_int | issue_ld_buf) begin
         res_d[0] = 1'b1;
         own_d[0] = {2{issue_ld_buf}};
      end
      if (issue_mult) begin
         res_d[MULT_LAT-1] = 1'b1;
         own_d[MULT_LAT-1] = 2'b01;
      end
      if (issue_div) begin
         res_d[DIV_LAT-1] = 1'b1;
         own_d[DIV_LAT-1] = 2'b10;
      end
      div_cnt_d = issue_div ? 4'(DIV_LAT) : div_cnt_q - {3'b000, div_busy};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         res_q     <= '0;
         own_q     <= '0;
         div_cnt_q <= '0;
      end else begin
         res_q     <= res_d;
         own_q     <= own_d;
         div_cnt_q <= div_cnt_d;
      end
   end
endmodule

// File: tb/tb_cdb_issue_scheduler.sv
// tb_cdb_issue_scheduler: vector table of grants/div_busy plus a CDB landing scoreboard.
module tb_cdb_issue_scheduler;
   localparam int ML = 4;
   localparam int DL = 7;

   logic clk = 1'b0;
   logic reset, ready_int, ready_mult, ready_div, ready_ld_buf;
   logic issue_int, issue_mult, issue_div, issue_ld_buf;
   logic div_busy, cdb_valid;
   logic [1:0] cdb_sel;

   always #5 clk = ~clk;

   cdb_issue_scheduler #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
      .clk(clk), .reset(reset),
      .ready_int(ready_int), .ready_mult(ready_mult), .ready_div(ready_div), .ready_ld_buf(ready_ld_buf),
      .issue_int(issue_int), .issue_mult(issue_mult), .issue_div(issue_div), .issue_ld_buf(issue_ld_buf),
      .div_busy(div_busy), .cdb_valid(cdb_valid), .cdb_sel(cdb_sel)
   );

   // rdy/iss bit order: {int, mult, div, ld_buf}
   typedef struct {
      logic       rst;
      logic [3:0] rdy;
      logic [3:0] iss;
      logic       busy;
   } vec_t;

   typedef struct {
      int         cyc;
      logic [1:0] sel;
   } land_t;

   vec_t  tv[$];
   land_t sb[$];
   int    cyc = 0;
   int    n_chk = 0;
   int    n_fail = 0;

   task automatic chk(input string n, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", n, cyc, got, exp);
      end
   endtask

   task automatic add(input logic r, input logic [3:0] rdy, input logic [3:0] iss, input logic b);
      vec_t v;
      v.rst = r; v.rdy = rdy; v.iss = iss; v.busy = b;
      tv.push_back(v);
   endtask

   task automatic push(input int at, input logic [1:0] sel);
      land_t e;
      e.cyc = at; e.sel = sel;
      sb.push_back(e);
   endtask

   task automatic step(input logic r, input logic [3:0] rdy, input logic [3:0] iss, input logic b);
      int idx;
      logic ev;
      logic [1:0] es;
      reset = r;
      {ready_int, ready_mult, ready_div, ready_ld_buf} = rdy;
      @(negedge clk);
      chk("issue", int'({issue_int, issue_mult, issue_div, issue_ld_buf}), int'(iss));
      chk("div_busy", int'(div_busy), int'(b));
      idx = -1;
      foreach (sb[k]) if (sb[k].cyc == cyc) idx = k;
      ev = idx >= 0;
      es = ev ? sb[idx].sel : 2'b00;
      if (ev) sb.delete(idx);
      chk("cdb_valid", int'(cdb_valid), int'(ev));
      chk("cdb_sel", int'(cdb_sel), int'(es));
      if (iss[3] | iss[0]) push(cyc + 1, iss[0] ? 2'b11 : 2'b00);
      if (iss[2]) push(cyc + ML, 2'b01);
      if (iss[1]) push(cyc + DL, 2'b10);
      if (r) for (int k = sb.size() - 1; k >= 0; k--) if (sb[k].cyc > cyc) sb.delete(k);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      reset = 1'b1;
      {ready_int, ready_mult, ready_div, ready_ld_buf} = 4'b0000;
      @(posedge clk);
      #1;
      repeat (3) add(1, 4'b1111, 4'b0000, 0);
      add(0, 4'b0010, 4'b0010, 0);
      repeat (5) add(0, 4'b0010, 4'b0000, 1);
      add(0, 4'b1010, 4'b0000, 1);
      add(0, 4'b1010, 4'b1000, 1);
      add(0, 4'b0010, 4'b0010, 0);
      repeat (2) add(0, 4'b0010, 4'b0000, 1);
      repeat (5) add(0, 4'b0000, 4'b0000, 1);
      add(0, 4'b0000, 4'b0000, 0);
      add(0, 4'b0100, 4'b0100, 0);
      repeat (2) add(0, 4'b0000, 4'b0000, 0);
      add(0, 4'b1000, 4'b0000, 0);
      add(0, 4'b1000, 4'b1000, 0);
      repeat (2) add(0, 4'b0000, 4'b0000, 0);
      add(0, 4'b0010, 4'b0010, 0);
      repeat (2) add(0, 4'b0000, 4'b0000, 1);
      add(0, 4'b0100, 4'b0000, 1);
      add(0, 4'b0100, 4'b0100, 1);
      repeat (3) add(0, 4'b0000, 4'b0000, 1);
      repeat (2) add(0, 4'b0000, 4'b0000, 0);
      add(1, 4'b0000, 4'b0000, 0);
`ifdef ISSUE_LRU_EN
      for (int i = 0; i < 6; i++) add(0, 4'b1001, (i % 2 == 1) ? 4'b0001 : 4'b1000, 0);
`else
      for (int i = 0; i < 6; i++) add(0, 4'b1001, 4'b1000, 0);
`endif
      repeat (2) add(0, 4'b0000, 4'b0000, 0);
      foreach (tv[i]) step(tv[i].rst, tv[i].rdy, tv[i].iss, tv[i].busy);
      // ld_buf lands during the reset cycle; the pending mult result must be dropped
      step(0, 4'b0100, 4'b0100, 0);
      step(0, 4'b0001, 4'b0001, 0);
      step(1, 4'b1111, 4'b0000, 0);
      repeat (3) step(0, 4'b0000, 4'b0000, 0);
      chk("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
